sim_controller: RTL and testbench

- Host-side sequencer that drives the Boolean-network simulation datapath: it sits on the other side of the datapath's start / inhibitor-load / initial-state interface.
- Accepts one job per command handshake: initial state, inhibitor mask and iteration limit. It loads the inhibitors one rule per cycle, pulses start, then watches steady_state and iteration_number until convergence or timeout.
- Returns final network state, iteration count and convergence flag on a response handshake.

---
 rtl/sim_pkg.sv | 35 +++
 rtl/inhib_loader.sv | 66 ++++++
 rtl/sim_controller.sv | 139 +++++++++++++
 tb/tb_sim_controller.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_pkg.sv
// sim_pkg: shared types and sizes for the Boolean-network simulation sequencer.
//   STATE_W   : network state width (from `STATE)
//   LOG_RULES : rule index width (from `LOG_RULES)
//   N_RULES   : number of inhibitable rules
//   ITER_W    : iteration counter / limit width
`ifndef STATE
`define STATE 16
`endif
`ifndef LOG_RULES
`define LOG_RULES 3
`endif

package sim_pkg;

   localparam int STATE_W   = `STATE;
   localparam int LOG_RULES = `LOG_RULES;
   localparam int N_RULES   = 2 ** LOG_RULES;
   localparam int ITER_W    = 10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_START  = 3'd2,
      ST_SETTLE = 3'd3,
      ST_RUN    = 3'd4,
      ST_RESP   = 3'd5
   } ctrl_state_e;

   typedef struct packed {
      logic [STATE_W-1:0] state;
      logic [ITER_W-1:0]  iter;
      logic               converged;
   } sim_rsp_t;

endpackage

// File: rtl/inhib_loader.sv
// inhib_loader: walks the rule index 0..N_RULES-1, one rule per cycle, and
// drives the datapath's inhibitor load strobe from the job's mask.
//   clk, rst       : clock, asynchronous active-low reset
//   go             : begin a walk at index 0 (job accept)
//   kill           : abandon the walk (abort)
//   mask           : inhibit mask; bit i = 1 loads an inhibit for rule i
//   ld_inhibitor   : registered load strobe for the current index
//   sel_inhibitor  : registered current rule index
//   done           : high during the last index of the walk
module inhib_loader
   import sim_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 go,
   input  logic                 kill,
   input  logic [N_RULES-1:0]   mask,
   output logic                 ld_inhibitor,
   output logic [LOG_RULES-1:0] sel_inhibitor,
   output logic                 done
);

   localparam logic [LOG_RULES-1:0] LAST_IDX = LOG_RULES'(N_RULES - 1);

   logic                 active_q, active_d;
   logic [LOG_RULES-1:0] idx_q, idx_d;
   logic                 ld_q, ld_d;

   always_comb begin
      active_d = active_q;
      idx_d    = idx_q;
      if (go) begin
         active_d = 1'b1;
         idx_d    = '0;
      end else if (active_q) begin
         // Leaving after the last index parks idx at 0 instead of wrapping
         // into another pass.
         if (kill || idx_q == LAST_IDX) begin
            active_d = 1'b0;
            idx_d    = '0;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
      // Strobe is computed from the next index so it lines up with the
      // cycle in which sel_inhibitor shows that index.
      ld_d = active_d & mask[idx_d];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         active_q <= 1'b0;
         idx_q    <= '0;
         ld_q     <= 1'b0;
      end else begin
         active_q <= active_d;
         idx_q    <= idx_d;
         ld_q     <= ld_d;
      end
   end

   assign ld_inhibitor  = ld_q;
   assign sel_inhibitor = idx_q;
   assign done          = active_q && (idx_q == LAST_IDX);

endmodule

// File: rtl/sim_controller.sv
// sim_controller: host-side sequencer for the Boolean-network simulation
// datapath. Accepts a job (initial state, inhibit mask, iteration limit),
// loads inhibitors one rule per cycle, pulses start, then waits for
// convergence or the iteration limit and returns the result.
//   cmd_*        : job handshake and payload (cmd_ready high only in IDLE)
//   abort        : returns to IDLE from LOAD/START/SETTLE/RUN, no response
//   start, ld_inhibitor, sel_inhibitor, initial_state : datapath controls
//   network_state, steady_state, iteration_number     : datapath status
//   rsp_*        : result handshake and payload
//   busy         : controller not idle
module sim_controller
   import sim_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [STATE_W-1:0]   cmd_state,
   input  logic [N_RULES-1:0]   cmd_inhib,
   input  logic [ITER_W-1:0]    cmd_max_iter,
   input  logic                 abort,
   output logic                 start,
   output logic                 ld_inhibitor,
   output logic [LOG_RULES-1:0] sel_inhibitor,
   output logic [STATE_W-1:0]   initial_state,
   input  logic [STATE_W-1:0]   network_state,
   input  logic                 steady_state,
   input  logic [ITER_W-1:0]    iteration_number,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [STATE_W-1:0]   rsp_state,
   output logic [ITER_W-1:0]    rsp_iter,
   output logic                 rsp_converged,
   output logic                 busy
);

   ctrl_state_e          state_q, state_d;
   logic [STATE_W-1:0]   init_q, init_d;
   logic [N_RULES-1:0]   mask_q, mask_d;
   logic [ITER_W-1:0]    lim_q, lim_d;
   logic                 start_q, start_d;
   logic                 rsp_valid_q, rsp_valid_d;
   sim_rsp_t             rsp_q, rsp_d;

   logic                 accept;
   logic                 load_done;
   logic                 conv, tmo;

   assign accept = (state_q == ST_IDLE) && cmd_valid;
   assign conv   = steady_state;
   // A zero limit still stops at the counter's maximum so a run that never
   // converges cannot wrap the datapath counter and hang.
   assign tmo    = (lim_q != '0) ? (iteration_number >= lim_q) : (&iteration_number);

   always_comb begin
      state_d = state_q;
      init_d  = init_q;
      mask_d  = mask_q;
      lim_d   = lim_q;
      rsp_d   = rsp_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               state_d = ST_LOAD;
               init_d  = cmd_state;
               mask_d  = cmd_inhib;
               lim_d   = cmd_max_iter;
            end
         end
         ST_LOAD: begin
            if (abort)          state_d = ST_IDLE;
            else if (load_done) state_d = ST_START;
         end
         ST_START:  state_d = abort ? ST_IDLE : ST_SETTLE;
         // One cycle in which steady_state left over from a previous job is
         // deliberately not looked at.
         ST_SETTLE: state_d = abort ? ST_IDLE : ST_RUN;
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (conv || tmo) begin
               state_d         = ST_RESP;
               rsp_d.state     = network_state;
               rsp_d.iter      = iteration_number;
               rsp_d.converged = conv;
            end
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Registered outputs follow the state being entered so they are
      // valid throughout the matching state cycle.
      start_d     = (state_d == ST_START);
      rsp_valid_d = (state_d == ST_RESP);
   end

   inhib_loader u_loader (
      .clk           (clk),
      .rst           (rst),
      .go            (accept),
      .kill          (abort && (state_q == ST_LOAD)),
      .mask          (mask_d),
      .ld_inhibitor  (ld_inhibitor),
      .sel_inhibitor (sel_inhibitor),
      .done          (load_done)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         init_q      <= '0;
         mask_q      <= '0;
         lim_q       <= '0;
         start_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_q       <= '0;
      end else begin
         state_q     <= state_d;
         init_q      <= init_d;
         mask_q      <= mask_d;
         lim_q       <= lim_d;
         start_q     <= start_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_q       <= rsp_d;
      end
   end

   assign cmd_ready     = (state_q == ST_IDLE);
   assign busy          = (state_q != ST_IDLE);
   assign start         = start_q;
   assign initial_state = init_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_state     = rsp_q.state;
   assign rsp_iter      = rsp_q.iter;
   assign rsp_converged = rsp_q.converged;

endmodule

// File: tb/tb_sim_controller.sv
// tb_sim_controller: directed-vector bench for sim_controller. Inputs are
// driven 1 time unit after each rising edge, outputs checked at that point.
module tb_sim_controller;
   import sim_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 cmd_valid;
   logic                 cmd_ready;
   logic [STATE_W-1:0]   cmd_state;
   logic [N_RULES-1:0]   cmd_inhib;
   logic [ITER_W-1:0]    cmd_max_iter;
   logic                 abort;
   logic                 start;
   logic                 ld_inhibitor;
   logic [LOG_RULES-1:0] sel_inhibitor;
   logic [STATE_W-1:0]   initial_state;
   logic [STATE_W-1:0]   network_state;
   logic                 steady_state;
   logic [ITER_W-1:0]    iteration_number;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [STATE_W-1:0]   rsp_state;
   logic [ITER_W-1:0]    rsp_iter;
   logic                 rsp_converged;
   logic                 busy;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   sim_controller dut (
      .clk              (clk),
      .rst              (rst),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_state        (cmd_state),
      .cmd_inhib        (cmd_inhib),
      .cmd_max_iter     (cmd_max_iter),
      .abort            (abort),
      .start            (start),
      .ld_inhibitor     (ld_inhibitor),
      .sel_inhibitor    (sel_inhibitor),
      .initial_state    (initial_state),
      .network_state    (network_state),
      .steady_state     (steady_state),
      .iteration_number (iteration_number),
      .rsp_valid        (rsp_valid),
      .rsp_ready        (rsp_ready),
      .rsp_state        (rsp_state),
      .rsp_iter         (rsp_iter),
      .rsp_converged    (rsp_converged),
      .busy             (busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer a job from IDLE and advance to the first RUN cycle, checking the
   // start pulse lands N_RULES+1 cycles after the accept cycle.
   task automatic job(input logic [STATE_W-1:0] s, input logic [N_RULES-1:0] m,
                      input logic [ITER_W-1:0] l);
      cmd_state        = s;
      cmd_inhib        = m;
      cmd_max_iter     = l;
      cmd_valid        = 1'b1;
      iteration_number = '0;
      tick();
      cmd_valid = 1'b0;
      repeat (8) tick();
      chk("job_start_pulse", 32'(start), 32'd1);
      tick();
      tick();
   endtask

   // Hand-computed strobe pattern for mask 8'b1000_0101, index 0..7.
   logic ld_exp [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; cmd_valid = 1'b0; cmd_state = '0; cmd_inhib = '0;
      cmd_max_iter = '0; abort = 1'b0; network_state = '0;
      steady_state = 1'b0; iteration_number = '0; rsp_ready = 1'b0;
      #2;
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_start", 32'(start), 32'd0);
      chk("rst_ld", 32'(ld_inhibitor), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_init_state", 32'(initial_state), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // Job A: mask 1000_0101, no limit, converges at iteration 5.
      cmd_state = 16'hA5C3; cmd_inhib = 8'b1000_0101; cmd_max_iter = '0;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("a_sel", 32'(sel_inhibitor), 32'(i));
         chk("a_ld", 32'(ld_inhibitor), 32'(ld_exp[i]));
         chk("a_no_start", 32'(start), 32'd0);
         chk("a_cmd_ready", 32'(cmd_ready), 32'd0);
         tick();
      end
      chk("a_start_9", 32'(start), 32'd1);
      chk("a_ld_after", 32'(ld_inhibitor), 32'd0);
      chk("a_init_state", 32'(initial_state), 32'hA5C3);
      tick();
      chk("a_start_1cyc", 32'(start), 32'd0);
      tick();
      for (int k = 1; k <= 5; k++) begin
         chk("a_run_no_rsp", 32'(rsp_valid), 32'd0);
         iteration_number = ITER_W'(k);
         steady_state     = (k == 5);
         network_state    = STATE_W'(16'h1000 + k);
         tick();
      end
      steady_state = 1'b0;
      chk("a_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("a_rsp_iter", 32'(rsp_iter), 32'd5);
      chk("a_rsp_conv", 32'(rsp_converged), 32'd1);
      chk("a_rsp_state", 32'(rsp_state), 32'h1005);
      chk("a_init_hold", 32'(initial_state), 32'hA5C3);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("a_idle_ready", 32'(cmd_ready), 32'd1);
      chk("a_idle_busy", 32'(busy), 32'd0);
      chk("a_idle_rsp_valid", 32'(rsp_valid), 32'd0);

      // Job B: limit 20, never converges.
      job(16'h0F0F, 8'h00, 10'd20);
      for (int k = 18; k <= 20; k++) begin
         chk("b_run_no_rsp", 32'(rsp_valid), 32'd0);
         iteration_number = ITER_W'(k);
         network_state    = STATE_W'(16'h2000 + k);
         tick();
      end
      chk("b_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("b_rsp_iter", 32'(rsp_iter), 32'd20);
      chk("b_rsp_conv", 32'(rsp_converged), 32'd0);
      chk("b_rsp_state", 32'(rsp_state), 32'h2014);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Job B2: limit reached and steady in the same cycle -> converged.
      job(16'h0F0F, 8'h00, 10'd20);
      iteration_number = 10'd20; steady_state = 1'b1; network_state = 16'h5555;
      tick();
      chk("b2_rsp_conv", 32'(rsp_converged), 32'd1);
      chk("b2_rsp_iter", 32'(rsp_iter), 32'd20);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Job C: steady_state still high from the previous job.
      job(16'h7777, 8'h00, 10'd0);
      chk("c_stale_masked", 32'(rsp_valid), 32'd0);
      iteration_number = 10'd1; network_state = 16'h3333;
      tick();
      steady_state = 1'b0;
      chk("c_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("c_rsp_iter", 32'(rsp_iter), 32'd1);
      chk("c_rsp_state", 32'(rsp_state), 32'h3333);
      chk("c_rsp_conv", 32'(rsp_converged), 32'd1);

      // Consumer stalls 10 cycles; abort during RESP is ignored.
      for (int i = 0; i < 10; i++) begin
         iteration_number = ITER_W'(i * 7 + 100);
         network_state    = STATE_W'(16'hC000 + i);
         steady_state     = i[0];
         abort            = (i == 4);
         tick();
         chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("stall_rsp_iter", 32'(rsp_iter), 32'd1);
         chk("stall_rsp_state", 32'(rsp_state), 32'h3333);
         chk("stall_cmd_ready", 32'(cmd_ready), 32'd0);
      end
      abort = 1'b0; steady_state = 1'b0;

      // Release with a command already pending: not accepted in that cycle.
      cmd_state = 16'hBEEF; cmd_inhib = 8'hFF; cmd_max_iter = '0;
      cmd_valid = 1'b1; rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rel_busy", 32'(busy), 32'd0);
      tick();
      cmd_valid = 1'b0;
      chk("d_busy", 32'(busy), 32'd1);
      chk("d_sel0", 32'(sel_inhibitor), 32'd0);
      chk("d_ld0", 32'(ld_inhibitor), 32'd1);
      chk("d_init_state", 32'(initial_state), 32'hBEEF);
      repeat (3) tick();
      chk("d_sel3", 32'(sel_inhibitor), 32'd3);
      chk("d_ld3", 32'(ld_inhibitor), 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ld", 32'(ld_inhibitor), 32'd0);
      chk("abort_start", 32'(start), 32'd0);
      chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);

      // New command right after the abort; exercises the zero-limit hard stop.
      cmd_state = 16'h1357; cmd_inhib = 8'h00; cmd_max_iter = '0;
      cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chk("e_accept_busy", 32'(busy), 32'd1);
      chk("e_init_state", 32'(initial_state), 32'h1357);
      repeat (8) tick();
      chk("e_start", 32'(start), 32'd1);
      tick();
      tick();
      iteration_number = 10'd1022; network_state = 16'h0ABC;
      tick();
      chk("e_1022_no_rsp", 32'(rsp_valid), 32'd0);
      iteration_number = 10'd1023;
      tick();
      chk("e_hard_stop_valid", 32'(rsp_valid), 32'd1);
      chk("e_hard_stop_iter", 32'(rsp_iter), 32'd1023);
      chk("e_hard_stop_conv", 32'(rsp_converged), 32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Reset in the middle of RUN.
      job(16'h4242, 8'h10, 10'd0);
      iteration_number = 10'd3;
      tick();
      chk("f_running", 32'(busy), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("f_async_busy", 32'(busy), 32'd0);
      chk("f_async_ready", 32'(cmd_ready), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      tick();
      chk("f_busy", 32'(busy), 32'd0);
      chk("f_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("f_start", 32'(start), 32'd0);
      chk("f_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("f_init_state", 32'(initial_state), 32'd0);
      chk("f_rsp_iter", 32'(rsp_iter), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
